// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_arbiter
// Purpose  : Shares a single-port framebuffer RAM between VGA scanout (via a
//            show-ahead prefetch FIFO) and a pixel-drawing write client.
//            Optional underrun event counter: VGA_FB_ARB_UNDERRUN_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
   parameter int DW         = 16,
   parameter int AW         = 17,
   parameter int FB_WORDS   = 76800,
   parameter int FIFO_DEPTH = 16,
   parameter int LOW_WM     = 4,
   parameter int RD_LAT     = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          frame_start,
   input  logic          pix_rd,
   output logic [DW-1:0] pix_data,
   output logic          pix_valid,
   output logic          underrun,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [15:0]   underrun_cnt
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
   localparam logic [0:0]    ST_IDLE   = 1'b0;
   localparam logic [0:0]    ST_FETCH  = 1'b1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(FB_WORDS - 1);

   logic [0:0]        state, state_nxt;
   logic              fetch_active;
   logic [AW-1:0]     fetch_addr;
   logic [RD_LAT-1:0] rd_pipe;
   logic [DW-1:0]     fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]     rd_ptr, wr_ptr, rd_ptr_after;
   logic [LW-1:0]     level, level_after;
   logic [CW-1:0]     inflight, credit;
   logic              disp_elig, disp_urgent;
   logic              grant_wr, grant_rd;
   logic              push, pop, empty_hit;

   // Count reads still in the RAM pipeline
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++)
         inflight = inflight + CW'(rd_pipe[i]);
   end

   assign credit      = CW'(level) + inflight;
   assign disp_elig   = fetch_active && (credit < CW'(FIFO_DEPTH));
   assign disp_urgent = fetch_active && (credit < CW'(LOW_WM));
   assign wr_ready    = !disp_urgent;
   assign pix_valid   = (level != '0);

   // frame_start suppresses reads and discards returns/pops, but not a write
   assign grant_wr  = wr_valid && wr_ready;
   assign grant_rd  = !grant_wr && disp_elig && !frame_start;
   assign push      = rd_pipe[RD_LAT-1] && !frame_start;
   assign pop       = pix_rd && pix_valid && !frame_start;
   assign empty_hit = pix_rd && !pix_valid && !frame_start;

   assign level_after  = level - LW'(pop);
   assign rd_ptr_after = rd_ptr + PW'(pop);

   // Drive the RAM port from this cycle's grant
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (grant_wr) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = wr_addr;
         mem_wdata = wr_data;
      end else if (grant_rd) begin
         mem_en    = 1'b1;
         mem_addr  = fetch_addr;
      end
   end

   // Fetch FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Fetch FSM: next state (stop after the last word of the frame)
   always_comb begin
      state_nxt = state;
      if (frame_start)
         state_nxt = ST_FETCH;
      else if (grant_rd && (fetch_addr == LAST_ADDR))
         state_nxt = ST_IDLE;
   end

   // Fetch FSM: outputs
   always_comb begin
      fetch_active = (state == ST_FETCH);
   end

   // Fetch address counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           fetch_addr <= '0;
      else if (frame_start) fetch_addr <= '0;
      else if (grant_rd)    fetch_addr <= fetch_addr + 1'b1;
   end

   // In-flight tracker: one bit per read, tail marks data arriving now
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pipe <= '0;
      end else if (frame_start) begin
         rd_pipe <= '0;
      end else begin
         rd_pipe[0] <= grant_rd;
         for (int i = 1; i < RD_LAT; i++)
            rd_pipe[i] <= rd_pipe[i-1];
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else if (frame_start) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr <= rd_ptr_after;
         level  <= level_after + LW'(push);
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= mem_rdata;
   end

   // Registered show-ahead head; holds its last value while the FIFO is empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_data <= '0;
      end else if (!frame_start) begin
         if (push && (level_after == '0))
            pix_data <= mem_rdata;
         else if (level_after != '0)
            pix_data <= fifo_mem[rd_ptr_after];
      end
   end

   // Sticky underrun flag, cleared at each frame start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           underrun <= 1'b0;
      else if (frame_start) underrun <= 1'b0;
      else if (empty_hit)   underrun <= 1'b1;
   end

`ifdef VGA_FB_ARB_UNDERRUN_CNT_EN
   // Saturating underrun event counter, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         underrun_cnt <= '0;
      else if (empty_hit && (underrun_cnt != 16'hFFFF))
         underrun_cnt <= underrun_cnt + 16'd1;
   end
`else
   assign underrun_cnt = 16'h0;
`endif

`ifndef SYNTHESIS
   // Credit accounting must never let a return arrive at a full FIFO
   always_ff @(posedge clk) begin
      if (rst_n) assert (!(push && (level == LW'(FIFO_DEPTH))));
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_fb_arbiter
// Purpose  : Table-driven bench for vga_fb_arbiter plus a short-frame instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_fb_arbiter;

   typedef struct {
      logic        fs, rd, wv;
      logic [16:0] waddr;
      logic [15:0] wdata;
      logic        en, we;
      logic [16:0] addr;
      logic [15:0] wd;
      logic        wrdy, pv;
      logic [15:0] pd;
      logic        ur;
   } vec_t;

`ifdef VGA_FB_ARB_UNDERRUN_CNT_EN
   localparam logic [15:0] UCNT_EXP = 16'd3;
`else
   localparam logic [15:0] UCNT_EXP = 16'd0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // main instance
   logic        frame_start = 0, pix_rd = 0, wr_valid = 0;
   logic [16:0] wr_addr = 0;
   logic [15:0] wr_data = 0;
   logic [15:0] pix_data, mem_wdata, mem_rdata, underrun_cnt;
   logic        pix_valid, underrun, wr_ready, mem_en, mem_we;
   logic [16:0] mem_addr;

   // short-frame instance
   logic        fs2 = 0;
   logic [15:0] pix_data2, mem_wdata2, underrun_cnt2;
   logic        pix_valid2, underrun2, wr_ready2, mem_en2, mem_we2;
   logic [16:0] mem_addr2;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic logic [15:0] f(input logic [16:0] a);
      return {a[7:0], ~a[7:0]};
   endfunction

   vga_fb_arbiter u_dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_rd(pix_rd),
      .pix_data(pix_data), .pix_valid(pix_valid), .underrun(underrun),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .underrun_cnt(underrun_cnt)
   );

   vga_fb_arbiter #(.FB_WORDS(8)) u_small (
      .clk(clk), .rst_n(rst_n), .frame_start(fs2), .pix_rd(1'b0),
      .pix_data(pix_data2), .pix_valid(pix_valid2), .underrun(underrun2),
      .wr_valid(1'b0), .wr_ready(wr_ready2), .wr_addr(17'd0), .wr_data(16'd0),
      .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
      .mem_rdata(16'h0), .underrun_cnt(underrun_cnt2)
   );

   // RAM model: content is f(addr), read data appears two cycles after the read
   logic [16:0] p0 = 0, p1 = 0;
   always @(posedge clk) begin
      p0 <= mem_addr;
      p1 <= p0;
   end
   assign mem_rdata = f(p1);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic fs, rd, wv, input logic [16:0] waddr,
                               input logic [15:0] wdata, input logic en, we,
                               input logic [16:0] addr, input logic wrdy, pv,
                               input logic [15:0] pd, input logic ur);
      vec_t v;
      v.fs = fs; v.rd = rd; v.wv = wv; v.waddr = waddr; v.wdata = wdata;
      v.en = en; v.we = we; v.addr = addr; v.wd = wdata;
      v.wrdy = wrdy; v.pv = pv; v.pd = pd; v.ur = ur;
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      int nreads;
      int i;
      // ---- vector table ----
      // writer owns the RAM before any frame_start
      for (i = 0; i < 3; i++)
         tbl.push_back(mk(0,0,1, 17'(100+i), 16'(16'h1110+i), 1,1, 17'(100+i), 1,0, 16'h0, 0));
      // frame_start, then 16 back-to-back reads filling the FIFO
      tbl.push_back(mk(1,0,0, 0,0, 0,0, 0, 1,0, 16'h0, 0));
      for (i = 0; i < 20; i++)
         tbl.push_back(mk(0,0,0, 0,0, i<16,0, 17'(i), i>=4, i>=3, (i>=3) ? f(0) : 16'h0, 0));
      // continuous scanout with a greedy writer: writer starved once credit < 4
      for (i = 0; i < 20; i++)
         if (i <= 12)
            tbl.push_back(mk(0,1,1, 17'(200+i), 16'(16'hB000+i), 1,1, 17'(200+i), 1,1, f(17'(i)), 0));
         else
            tbl.push_back(mk(0,1,1, 17'(200+i), 16'(16'hB000+i), 1,0, 17'(16+i-13), 0,1, f(17'(i)), 0));
      // frame_start with two reads in flight, then reads on an empty FIFO
      tbl.push_back(mk(1,0,0, 0,0, 0,0, 0, 0,1, f(20), 0));
      for (i = 1; i <= 3; i++)
         tbl.push_back(mk(0,1,0, 0,0, 1,0, 17'(i-1), 0,0, f(20), i>1));
      tbl.push_back(mk(0,0,0, 0,0, 1,0, 17'd3, 0,1, f(0), 1));
      for (i = 5; i <= 7; i++)
         tbl.push_back(mk(0,0,0, 0,0, 1,0, 17'(i-1), 1,1, f(0), 1));
      // frame_start with a same-cycle write grant, then refetch from 0
      tbl.push_back(mk(1,0,1, 17'd300, 16'hC0DE, 1,1, 17'd300, 1,1, f(0), 1));
      tbl.push_back(mk(0,0,0, 0,0, 1,0, 17'd0, 0,0, f(0), 0));

      // ---- reset ----
      repeat (3) @(negedge clk);
      #1;
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_pix_data", pix_data, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_ucnt", underrun_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // ---- apply table ----
      foreach (tbl[k]) begin
         @(negedge clk);
         frame_start = tbl[k].fs;
         pix_rd      = tbl[k].rd;
         wr_valid    = tbl[k].wv;
         wr_addr     = tbl[k].waddr;
         wr_data     = tbl[k].wdata;
         #1;
         chk($sformatf("v%0d_mem_en", k), mem_en, tbl[k].en);
         if (tbl[k].en) begin
            chk($sformatf("v%0d_mem_we", k), mem_we, tbl[k].we);
            chk($sformatf("v%0d_mem_addr", k), mem_addr, tbl[k].addr);
            if (tbl[k].we)
               chk($sformatf("v%0d_mem_wdata", k), mem_wdata, tbl[k].wd);
         end
         chk($sformatf("v%0d_wr_ready", k), wr_ready, tbl[k].wrdy);
         chk($sformatf("v%0d_pix_valid", k), pix_valid, tbl[k].pv);
         chk($sformatf("v%0d_pix_data", k), pix_data, tbl[k].pd);
         chk($sformatf("v%0d_underrun", k), underrun, tbl[k].ur);
      end
      @(negedge clk);
      frame_start = 0; pix_rd = 0; wr_valid = 0;
      #1;
      chk("ucnt_after_frame", underrun_cnt, 32'(UCNT_EXP));

      // ---- short frame: exactly 8 reads, no wrap ----
      @(negedge clk);
      fs2 = 1'b1;
      #1;
      chk("small_fs_no_read", mem_en2, 0);
      @(negedge clk);
      fs2 = 1'b0;
      nreads = 0;
      for (int c = 0; c < 30; c++) begin
         #1;
         if (mem_en2 && !mem_we2) begin
            chk($sformatf("small_rd%0d_addr", nreads), mem_addr2, 32'(nreads));
            nreads++;
         end
         @(negedge clk);
      end
      chk("small_read_count", nreads, 8);
      chk("small_pix_valid", pix_valid2, 1);
      fs2 = 1'b1;
      @(negedge clk);
      fs2 = 1'b0;
      #1;
      chk("small_refetch_en", mem_en2, 1);
      chk("small_refetch_addr", mem_addr2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM between two clients: the VGA scanout path and a drawing client that writes pixels.
- Scanout is fed from a small prefetch FIFO that the arbiter keeps topped up, so the pixel pipeline never waits on memory.
- The drawing client gets every memory cycle the scanout does not urgently need.
- Sits between the VGA timing/pixel logic and the framebuffer RAM.

Parameters:
DW, 16, pixel/word width (RGB565)
AW, 17, framebuffer address width
FB_WORDS, 76800, words per frame (320x240); fetch address range 0..FB_WORDS-1
FIFO_DEPTH, 16, prefetch FIFO entries (power of 2, >= 4)
LOW_WM, 4, urgency threshold on (fifo level + reads in flight), 1 <= LOW_WM < FIFO_DEPTH
RD_LAT, 2, fixed RAM read latency in cycles (>= 1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse: restart fetch at address 0, flush FIFO
pix_rd  in  1  scanout consumes head pixel this cycle
pix_data  out  DW  FIFO head (show-ahead)
pix_valid  out  1  FIFO not empty
underrun  out  1  sticky: pix_rd seen with FIFO empty since last frame_start
wr_valid  in  1  writer request
wr_ready  out  1  writer may transfer this cycle
wr_addr  in  AW  write address
wr_data  in  DW  write data
mem_en  out  1  RAM access this cycle
mem_we  out  1  1=write, 0=read
mem_addr  out  AW  RAM address
mem_wdata  out  DW  RAM write data
mem_rdata  in  DW  RAM read data, valid RD_LAT cycles after a read
underrun_cnt  out  16  underrun event counter (optional feature)

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk. Reset values: fetch_active=0, fetch_addr=0, FIFO empty, in-flight tracker clear, underrun=0, pix_valid=0, pix_data=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, wr_ready=1.
- credit = fifo_level + inflight, where inflight = number of reads issued whose data has not yet returned, tracked by an RD_LAT-deep valid shift register.
- disp_elig = fetch_active && credit < FIFO_DEPTH.
- disp_urgent = fetch_active && credit < LOW_WM.
- wr_ready = !disp_urgent. It is combinational from registered state only and never depends on wr_valid.
- Per-cycle grant:
  - wr_valid && wr_ready: write. mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - Otherwise, if disp_elig: read. mem_en=1, mem_we=0, mem_addr=fetch_addr, fetch_addr+1; a 1 enters the in-flight tracker.
  - Otherwise: mem_en=0.
- Memory outputs are combinational from the grant. The RAM samples them at the clk edge.
- Fetch address: when a read is issued at fetch_addr = FB_WORDS-1, fetch_active drops to 0. No further reads are issued until the next frame_start. Reads never wrap mid-frame.
- Read return: tracker tail=1 -> push mem_rdata into FIFO in that cycle. Credit accounting guarantees no push when full; a push when full is an assertion error.
- Pop: pix_rd && pix_valid -> advance head. Push and pop in the same cycle leave the level unchanged.
- Underrun: pix_rd && !pix_valid -> underrun<=1. pix_data holds its previous value. No pop occurs.
- frame_start (wins over all same-cycle events except a write grant):
  - FIFO flushed.
  - In-flight tracker cleared, so returns already in the pipe are discarded.
  - fetch_addr<=0, fetch_active<=1, underrun<=0.
  - A same-cycle pix_rd is ignored.
  - A same-cycle write grant still completes.
  - No read is issued in the frame_start cycle. Reads may start the next cycle.
- Before the first frame_start, the writer has the RAM every cycle.

Optional Feature:
- Macro: VGA_FB_ARB_UNDERRUN_CNT_EN.
- Defined: underrun_cnt increments by 1 on each cycle with pix_rd && !pix_valid. It saturates at 16'hFFFF, is reset to 0 by rst_n only, and is not cleared by frame_start.
- Undefined: underrun_cnt is tied to 16'h0 and no counter logic is built.

Test Plan:
- Reset, then wr_valid=1 continuously with no frame_start -> wr_ready=1 every cycle, mem_we=1 every cycle, mem_addr follows wr_addr.
- frame_start, no writer, no pix_rd (RD_LAT=2) -> reads at addresses 0..15 on consecutive cycles, then mem_en=0. pix_valid rises 3 cycles after the first read. FIFO level settles at 16.
- Continuing the previous case, pix_rd every cycle with wr_valid=1 -> no underrun. Whenever credit<4, wr_ready=0 and a read is issued; otherwise writes are granted.
- frame_start issued while 2 reads are in flight -> those 2 returns are not pushed, pix_valid=0 the next cycle, next read address=0.
- pix_rd on an empty FIFO for 3 cycles -> underrun=1 and held until frame_start; underrun_cnt=3 with the macro defined, 0 without.
- Small config, FB_WORDS=8 -> exactly 8 reads (addresses 0..7), then no more reads until the next frame_start.
